// File: rtl/stopwatch_pkg.sv
// Shared constants, converter state encoding and 7-segment decode for stopwatch_display.
package stopwatch_pkg;

   localparam logic [1:0] ST_IDLE  = 2'b00;
   localparam logic [1:0] ST_RUN   = 2'b01;
   localparam logic [1:0] ST_PAUSE = 2'b10;
   localparam logic [1:0] ST_RSVD  = 2'b11;

   typedef enum logic [1:0] {CS_IDLE, CS_SHIFT, CS_DONE} conv_state_t;

   // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_DASH  = 7'b0111111;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   function automatic logic [6:0] digit_seg(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/stopwatch_display_bin2bcd.sv
// Sequential shift-add-3 converter: 7-bit binary (0..99) to two BCD nibbles in 7 shift cycles.
module bin2bcd_seq (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [6:0] bin,
   output logic [3:0] tens,
   output logic [3:0] ones,
   output logic       done
);

   logic [14:0] sreg;
   logic [2:0]  cnt;
   logic [3:0]  t_adj;
   logic [3:0]  o_adj;

   always_comb begin
      t_adj = (sreg[14:11] >= 4'd5) ? sreg[14:11] + 4'd3 : sreg[14:11];
      o_adj = (sreg[10:7]  >= 4'd5) ? sreg[10:7]  + 4'd3 : sreg[10:7];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sreg <= '0;
         cnt  <= '0;
      end else if (start) begin
         sreg <= {8'd0, bin};
         cnt  <= 3'd7;
      end else if (cnt != 3'd0) begin
         sreg <= {t_adj[2:0], o_adj, sreg[6:0], 1'b0};
         cnt  <= cnt - 3'd1;
      end
   end

   // done marks the cycle of the final shift; tens/ones are final from the next cycle on
   assign done = (cnt == 3'd1);
   assign tens = sreg[14:11];
   assign ones = sreg[10:7];

endmodule

// File: rtl/stopwatch_display.sv
// MM.SS multiplexed common-anode 7-segment driver for the stopwatch outputs.
// Optional LEADING_ZERO_BLANK_EN blanks the minutes-tens digit when it is zero.
module stopwatch_display #(
   parameter int SCAN_DIV    = 1000,
   parameter int BLINK_SCANS = 256
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] minutes,
   input  logic [5:0] seconds,
   input  logic [1:0] status,
   output logic [6:0] seg_n,
   output logic [3:0] an_n,
   output logic       dp_n,
   output logic       bcd_valid,
   output logic       ovf
);
   import stopwatch_pkg::*;

   localparam int SW = $clog2(SCAN_DIV);
   localparam int BW = $clog2(BLINK_SCANS + 1);
   localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_SCANS - 1);

   conv_state_t      state;
   logic [7:0]       snap_min;
   logic [5:0]       snap_sec;
   logic             snap_vld;
   logic             start;
   logic [6:0]       min_sat;
   logic [3:0]       m_tens, m_ones, s_tens, s_ones;
   logic             m_done, s_done;
   logic [3:0][3:0]  digits;

   logic [SW-1:0]    scan_cnt;
   logic [1:0]       dig_idx;
   logic [BW-1:0]    blink_cnt;
   logic             blink_on;
   logic             scan_wrap, frame_wrap;
   logic [3:0]       cur_digit;
   logic [6:0]       seg_next;
   logic             dp_next;

   always_comb begin
      start   = (state == CS_IDLE) &&
                (!snap_vld || minutes != snap_min || seconds != snap_sec);
      min_sat = (minutes > 8'd99) ? 7'd99 : minutes[6:0];
   end

   bin2bcd_seq u_min (
      .clk(clk), .rst_n(rst_n), .start(start), .bin(min_sat),
      .tens(m_tens), .ones(m_ones), .done(m_done)
   );

   bin2bcd_seq u_sec (
      .clk(clk), .rst_n(rst_n), .start(start), .bin({1'b0, seconds}),
      .tens(s_tens), .ones(s_ones), .done(s_done)
   );

   // Snapshot holds raw minutes so a change above 99 still retriggers a conversion
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= CS_IDLE;
         snap_min  <= '0;
         snap_sec  <= '0;
         snap_vld  <= 1'b0;
         ovf       <= 1'b0;
         digits    <= '0;
         bcd_valid <= 1'b0;
      end else begin
         bcd_valid <= 1'b0;
         case (state)
            CS_IDLE: if (start) begin
               snap_min <= minutes;
               snap_sec <= seconds;
               snap_vld <= 1'b1;
               ovf      <= (minutes > 8'd99);
               state    <= CS_SHIFT;
            end
            CS_SHIFT: if (m_done && s_done) state <= CS_DONE;
            CS_DONE: begin
               digits    <= {m_tens, m_ones, s_tens, s_ones};
               bcd_valid <= 1'b1;
               state     <= CS_IDLE;
            end
            default: state <= CS_IDLE;
         endcase
      end
   end

   always_comb begin
      scan_wrap  = (scan_cnt == SCAN_LAST);
      frame_wrap = scan_wrap && (dig_idx == 2'd3);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scan_cnt  <= '0;
         dig_idx   <= '0;
         blink_cnt <= '0;
         blink_on  <= 1'b1;
      end else begin
         scan_cnt <= scan_wrap ? '0 : scan_cnt + SW'(1);
         if (scan_wrap) dig_idx <= dig_idx + 2'd1;
         if (status != ST_PAUSE) begin
            blink_on  <= 1'b1;
            blink_cnt <= '0;
         end else if (frame_wrap) begin
            if (blink_cnt == BLINK_LAST) begin
               blink_cnt <= '0;
               blink_on  <= ~blink_on;
            end else begin
               blink_cnt <= blink_cnt + BW'(1);
            end
         end
      end
   end

   // Decoration priority: reserved dash, then pause blank, then leading-zero blank
   always_comb begin
      cur_digit = digits[dig_idx];
      seg_next  = digit_seg(cur_digit);
      dp_next   = !((dig_idx == 2'd2) && (status != ST_IDLE));
`ifdef LEADING_ZERO_BLANK_EN
      if (dig_idx == 2'd3 && cur_digit == 4'd0) seg_next = SEG_BLANK;
`else
`endif
      if (status == ST_PAUSE && !blink_on) begin
         seg_next = SEG_BLANK;
         dp_next  = 1'b1;
      end
      if (status == ST_RSVD) begin
         seg_next = SEG_DASH;
         dp_next  = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         an_n  <= 4'hF;
         seg_n <= SEG_BLANK;
         dp_n  <= 1'b1;
      end else begin
         an_n  <= ~(4'b0001 << dig_idx);
         seg_n <= seg_next;
         dp_n  <= dp_next;
      end
   end

endmodule

// File: doc/stopwatch_display.md
Name: stopwatch_display

Overview:
Consumer end of the stopwatch output interface: takes the stopwatch's `minutes`, `seconds` and `status` and drives a 4-digit multiplexed common-anode 7-segment display as MM.SS. It contains:
- a sequential binary-to-BCD converter (shift-add-3),
- a digit scan counter,
- status-dependent decoration (blink while paused, dash pattern for an illegal status).

It sits between `stopwatch_top` and the board pins.

Parameters:
- SCAN_DIV, 1000, clock cycles each digit stays enabled (>=2)
- BLINK_SCANS, 256, full 4-digit scan frames per blink half-period (>=1)

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- minutes  input  8  binary minutes from stopwatch
- seconds  input  6  binary seconds (0..59) from stopwatch
- status  input  2  00 IDLE, 01 RUNNING, 10 PAUSED, 11 reserved
- seg_n  output  7  active-low segments {g,f,e,d,c,b,a}
- an_n  output  4  active-low one-hot digit enable; bit0 = seconds ones, bit3 = minutes tens
- dp_n  output  1  active-low decimal point
- bcd_valid  output  1  one-cycle pulse when the digit registers update
- ovf  output  1  high while displayed minutes are saturated (minutes > 99)

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: seg_n=7'h7F, an_n=4'hF, dp_n=1, bcd_valid=0, ovf=0.
  - Internal: digit registers=0, scan counter=0, digit index=0, blink phase=on, snapshot-valid=0.
- Converter FSM, states IDLE, SHIFT, DONE:
  - IDLE: if snapshot-valid=0 or {minutes,seconds} differs from the snapshot, capture the inputs into the snapshot and go to SHIFT.
    - Minutes saturate to 99 at capture; ovf is registered at capture as (minutes>99).
  - SHIFT: 7 cycles, running minutes (7-bit) and seconds (6 bits zero-extended to 7) in parallel.
  - DONE: one cycle; write the digit registers and pulse bcd_valid; then go to IDLE.
  - Latency: an input change sampled at edge N gives updated digit registers and bcd_valid high after edge N+8.
  - Input changes during SHIFT/DONE are ignored. IDLE re-compares on the next cycle, so the final value is always converted.
- Scan:
  - The counter counts 0..SCAN_DIV-1 every cycle. At wrap, the digit index increments mod 4.
  - an_n is registered and reflects the digit index one cycle later. The first enabled digit is an_n=4'b1110, at the first edge after reset release.
- Segment pattern per digit:
  - Registered, aligned with an_n. Standard hex-free 0-9 decode.
  - Example: 0 gives seg_n=7'b1000000 and 8 gives 7'b0000000.
- dp_n: 0 on digit index 2 when status!=IDLE; otherwise 1.
- Status handling:
  - IDLE or RUNNING: digits shown normally.
  - PAUSED: the blink phase toggles every BLINK_SCANS completed frames (digit index wrapping 3->0). In the off phase, seg_n=7'h7F and dp_n=1; an_n keeps scanning.
  - Blink phase is reset to on whenever status!=PAUSED.
  - 11: every digit shows a dash (seg_n=7'b0111111) and dp_n=1. The converter is unaffected.
- Status change: takes effect on the next registered seg_n update (one cycle). No conversion is triggered.

Optional Feature:
Macro: LEADING_ZERO_BLANK_EN.
- Defined: the minutes-tens digit shows seg_n=7'h7F when its BCD value is 0, so 05.07 displays as " 5.07". If that digit is 0 and minutes-ones is also 0, only the tens digit is blanked.
- Undefined: all four digits are always shown, e.g. "05.07".

Decomposition:
- Package `stopwatch_pkg`:
  - status localparams ST_IDLE, ST_RUN, ST_PAUSE, ST_RSVD
  - converter state enum
  - SEG_DASH and SEG_BLANK constants
  - 10-entry digit-to-segment constant function
- Sub-module `bin2bcd_seq`:
  - 7-bit in, two BCD nibbles out, start/done handshake, fixed 7-cycle shift.
  - Instantiated twice, once for minutes and once for seconds.

Test Plan (SCAN_DIV=4, BLINK_SCANS=2):
- Reset release with minutes=0, seconds=0:
  - bcd_valid pulses once 8 cycles after the first post-reset edge.
  - an_n cycles 1110,1101,1011,0111 every 4 cycles.
  - seg_n=7'b1000000 on all digits; dp_n=1 (IDLE).
- minutes=12, seconds=34, status=01:
  - 8 cycles later, digits read 1,2,3,4 (seg_n 1111001, 0100100, 0110000, 0011001 on an_n bit3..bit0).
  - dp_n=0 only while an_n=1011.
- minutes=150:
  - ovf=1; minute digits show 9,9.
  - Return to minutes=7: ovf=0 and the display shows 07 (or " 7" with LEADING_ZERO_BLANK_EN).
- seconds changes 10->11 at cycle 2 of a conversion:
  - First bcd_valid shows 10.
  - A second conversion starts the next cycle and shows 11 after a further 9 cycles.
- status=10 held:
  - seg_n=7'h7F for 8 consecutive scans out of every 16 while an_n keeps scanning.
  - status=01 restores digits on the next cycle.
- status=11:
  - All digits seg_n=7'b0111111 and dp_n=1.
  - Assert rst_n=0 mid-scan: outputs immediately go to their reset values without waiting for a clock.
